// File: rtl/tqvp_rejunity_vga_capture.sv
// tqvp_rejunity_vga_capture: 1-bpp VGA receiver measuring sync timing and capturing one line of pixels
// Define VGA_CAP_CONT_EN to enable CTRL[3] continuous capture (re-arm after each completion).
module tqvp_rejunity_vga_capture #(
  parameter int CAP_BITS = 64,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int XW = CNT_W + 1;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LINES, S_CAPTURE} state_t;
  state_t state;
  logic arm, hpol, vpol, cont, done, hs_prev, vs_prev;
  logic [9:0] line, line_cnt;
  logic [CNT_W-1:0] xstart, h_cnt, hperiod, hwidth;
  logic [10:0] v_cnt, vlines;
  logic [XW-1:0] x_cnt, x_cur, x_idx;
  logic [63:0] cap;
  logic hs_act, vs_act, hs_lead, hs_trail, vs_lead, wr_en, ctrl_wr, hit, samp, last, unused_ok;
  assign uo_out = '0;
  assign data_ready = 1'b1;
  assign user_interrupt = done;
  assign unused_ok = &{1'b0, ui_in[7:3], data_in};
  assign hs_act = ui_in[0] ~^ hpol;
  assign vs_act = ui_in[1] ~^ vpol;
  assign hs_lead = hs_act & ~hs_prev;
  assign hs_trail = ~hs_act & hs_prev;
  assign vs_lead = vs_act & ~vs_prev;
  assign wr_en = data_write_n != 2'b11;
  assign ctrl_wr = wr_en && address == 6'h00;
  // The hsync edge cycle is sample offset 0, so the window test also runs on the LINES->CAPTURE cycle.
  assign hit = state == S_LINES && hs_lead && !vs_lead && line_cnt == line;
  assign x_cur = state == S_CAPTURE ? x_cnt : '0;
  assign x_idx = x_cur - XW'(xstart);
  assign samp = (hit || state == S_CAPTURE) && x_cur >= XW'(xstart) && x_idx < XW'(CAP_BITS);
  assign last = samp && x_idx == XW'(CAP_BITS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {arm, hpol, vpol, cont, done, hs_prev, vs_prev} <= '0;
      line <= '0;
      line_cnt <= '0;
      xstart <= '0;
      h_cnt <= '0;
      hperiod <= '0;
      hwidth <= '0;
      v_cnt <= '0;
      vlines <= '0;
      x_cnt <= '0;
      cap <= '0;
    end else begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      h_cnt <= hs_lead ? CNT_W'(1) : h_cnt + CNT_W'(h_cnt != '1);
      if (hs_lead) hperiod <= h_cnt;
      if (hs_trail) hwidth <= h_cnt;
      if (vs_lead) begin
        vlines <= v_cnt;
        v_cnt <= {10'b0, hs_lead};
      end else if (hs_lead && v_cnt != '1) v_cnt <= v_cnt + 11'd1;
      if (wr_en && address == 6'h04) line <= data_in[9:0];
      if (wr_en && address == 6'h08) xstart <= data_in[CNT_W-1:0];
      if (wr_en && address == 6'h0C) done <= 1'b0;
      if (ctrl_wr) begin
        arm <= data_in[0];
        hpol <= data_in[1];
        vpol <= data_in[2];
`ifdef VGA_CAP_CONT_EN
        cont <= data_in[3];
`endif
        state <= data_in[0] ? S_ARM : S_IDLE;
        if (data_in[0]) done <= 1'b0;
      end else begin
        if (samp) cap[x_idx[5:0]] <= ui_in[2];
        if (last) begin
          state <= cont ? S_ARM : S_IDLE;
          arm <= cont;
          done <= 1'b1;
        end else
          case (state)
            S_ARM: if (vs_lead) begin
              state <= S_LINES;
              line_cnt <= '0;
            end
            S_LINES: if (vs_lead) line_cnt <= '0;
              else if (hit) begin
                state <= S_CAPTURE;
                x_cnt <= XW'(1);
              end else if (hs_lead) line_cnt <= line_cnt + 10'd1;
            S_CAPTURE: x_cnt <= x_cnt + XW'(1);
            default: ;
          endcase
      end
    end
  end
  always_comb begin
    data_out = '0;
    if (data_read_n != 2'b11)
      case (address)
        6'h00: data_out = {28'b0, cont, vpol, hpol, arm};
        6'h04: data_out = {22'b0, line};
        6'h08: data_out = 32'(xstart);
        6'h0C: data_out = {30'b0, done, state != S_IDLE};
        6'h10: data_out = 32'(hperiod);
        6'h14: data_out = 32'(hwidth);
        6'h18: data_out = {21'b0, vlines};
        6'h20: data_out = cap[31:0];
        6'h24: data_out = cap[63:32];
        default: ;
      endcase
  end
endmodule

// File: tb/tb_tqvp_rejunity_vga_capture.sv
// tb_tqvp_rejunity_vga_capture: randomized sync/pixel stimulus checked every cycle against a timestamp-based model
module tb_tqvp_rejunity_vga_capture;
  localparam int CAPB = 64;
  localparam int P_IDLE = 0, P_ARM = 1, P_LINES = 2, P_CAP = 3;
  logic clk = 0, rst_n;
  logic [7:0] ui_in, uo_out;
  logic [5:0] address;
  logic [31:0] data_in, data_out;
  logic [1:0] data_write_n, data_read_n;
  logic data_ready, user_interrupt;
  logic hs, vs, px;
  int vec = 0, fails = 0;
  assign ui_in = {5'b0, px, vs, hs};
  always #5 clk = ~clk;
  tqvp_rejunity_vga_capture #(.CAP_BITS(CAPB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );
  // Video source: hp/ln position; sync pulses start at hp=0 / ln=0 so vsync and hsync lead together.
  int g_p = 100, g_w = 10, g_l = 20, g_vs = 2, g_mode = 0, hp = 0, ln = 0;
  bit g_run = 0, g_hhi = 0, g_vhi = 0;
  initial begin
    hs = 1; vs = 1; px = 0;
    forever begin
      @(posedge clk); #1;
      if (!g_run) begin hp = 0; ln = 0; end
      hs = (g_run && hp < g_w) ? g_hhi : !g_hhi;
      vs = (g_run && ln < g_vs) ? g_vhi : !g_vhi;
      px = g_mode != 0 ? (ln == 6 && (hp == 20 || hp == 21 || hp == 83)) : 1'($urandom);
      if (g_run) begin
        hp++;
        if (hp >= g_p) begin
          hp = 0;
          ln++;
          if (ln >= g_l) ln = 0;
        end
      end
    end
  end
  // Reference model: measurements from edge timestamps, capture from cycle offsets after the chosen edge.
  int cyc = 0, t_hl, hl_tot, hl_vs, m_ln, m_te, ph, age, k;
  logic m_arm, m_hpol, m_vpol, m_cont, m_done, m_hsp, m_vsp, hsa, vsa, hl, ht, vl, m_wr, setd;
  logic [9:0] m_line;
  logic [15:0] m_xstart, m_hper, m_hwid;
  logic [10:0] m_vlines;
  logic [63:0] m_cap;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      {m_arm, m_hpol, m_vpol, m_cont, m_done, m_hsp, m_vsp} = '0;
      m_line = '0; m_xstart = '0; m_hper = '0; m_hwid = '0; m_vlines = '0; m_cap = '0;
      ph = P_IDLE; t_hl = cyc + 1; hl_tot = 0; hl_vs = 0; m_ln = 0; m_te = 0;
    end else begin
      hsa = ui_in[0] ~^ m_hpol;
      vsa = ui_in[1] ~^ m_vpol;
      hl = hsa && !m_hsp;
      ht = !hsa && m_hsp;
      vl = vsa && !m_vsp;
      age = (cyc - t_hl > 65535) ? 65535 : cyc - t_hl;
      if (hl) begin m_hper = 16'(age); t_hl = cyc; end
      if (ht) m_hwid = 16'(age);
      if (vl) begin
        m_vlines = (hl_tot - hl_vs > 2047) ? 11'd2047 : 11'(hl_tot - hl_vs);
        hl_vs = hl_tot;
      end
      if (hl) hl_tot++;
      m_wr = data_write_n != 2'b11;
      setd = 0;
      if (m_wr && address == 6'h00) begin
        m_arm = data_in[0]; m_hpol = data_in[1]; m_vpol = data_in[2];
`ifdef VGA_CAP_CONT_EN
        m_cont = data_in[3];
`endif
        ph = data_in[0] ? P_ARM : P_IDLE;
        if (data_in[0]) m_done = 0;
      end else begin
        if (ph == P_ARM && vl) begin ph = P_LINES; m_ln = 0; end
        else if (ph == P_LINES && vl) m_ln = 0;
        else if (ph == P_LINES && hl) begin
          if (m_ln == int'(m_line)) begin ph = P_CAP; m_te = cyc; end
          else m_ln++;
        end
        if (ph == P_CAP) begin
          k = cyc - m_te - int'(m_xstart);
          if (k >= 0 && k < CAPB) begin
            m_cap[k] = ui_in[2];
            if (k == CAPB - 1) begin
              ph = m_cont ? P_ARM : P_IDLE;
              m_arm = m_cont;
              setd = 1;
            end
          end
        end
      end
      if (m_wr && address == 6'h04) m_line = data_in[9:0];
      if (m_wr && address == 6'h08) m_xstart = data_in[15:0];
      if (m_wr && address == 6'h0C) m_done = 0;
      if (setd) m_done = 1;
      m_hsp = hsa;
      m_vsp = vsa;
    end
  end
  function automatic logic [31:0] exp_rd(input logic [5:0] a);
    case (a)
      6'h00: return {28'b0, m_cont, m_vpol, m_hpol, m_arm};
      6'h04: return {22'b0, m_line};
      6'h08: return {16'b0, m_xstart};
      6'h0C: return {30'b0, m_done, ph != P_IDLE};
      6'h10: return {16'b0, m_hper};
      6'h14: return {16'b0, m_hwid};
      6'h18: return {21'b0, m_vlines};
      6'h20: return m_cap[31:0];
      6'h24: return m_cap[63:32];
      default: return 32'h0;
    endcase
  endfunction
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n === 1'b1) begin
      e = data_read_n == 2'b11 ? 32'h0 : exp_rd(address);
      vec++;
      if (data_out !== e || user_interrupt !== m_done || uo_out !== 8'h0 || data_ready !== 1'b1) begin
        fails++;
        $display("FAIL model cycle %0d addr %h: data_out=%h irq=%b uo=%h rdy=%b, required %h irq=%b uo=00 rdy=1",
                 cyc, address, data_out, user_interrupt, uo_out, data_ready, e, m_done);
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'($urandom_range(0, 2));
    tick();
    data_write_n = 2'b11;
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    address = a; data_read_n = 2'($urandom_range(0, 2));
    @(negedge clk);
    chk(nm, data_out, exp);
    tick();
    data_read_n = 2'b11;
  endtask
  task automatic rd_any(input logic [5:0] a);
    address = a; data_read_n = 2'($urandom_range(0, 2));
    tick();
    data_read_n = 2'b11;
  endtask
  task automatic wait_irq(input int n, input string nm);
    for (int i = 0; i < n && !user_interrupt; i++) tick();
    chk(nm, {31'b0, user_interrupt}, 32'h1);
  endtask
  logic [5:0] regs [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24};
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int ls, xs;
    rst_n = 0; address = 0; data_in = 0; data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_irq", {31'b0, user_interrupt}, 32'h0);
    chk("reset_uo", {24'b0, uo_out}, 32'h0);
    chk("reset_ready", {31'b0, data_ready}, 32'h1);
    foreach (regs[i]) rd(regs[i], 32'h0, "reset_reg");
    g_run = 1;
    repeat (4200) tick();
    rd(6'h10, 32'd100, "hperiod");
    rd(6'h14, 32'd10, "hwidth");
    rd(6'h18, 32'd20, "vlines");
    g_mode = 1;
    bus_wr(6'h04, 32'd5);
    bus_wr(6'h08, 32'd20);
    bus_wr(6'h00, 32'h1);
    wait_irq(7000, "cap_irq");
    rd(6'h20, 32'h00000003, "cap0");
    rd(6'h24, 32'h80000000, "cap1");
    rd(6'h0C, 32'h2, "status_done");
    rd(6'h00, 32'h0, "ctrl_arm_cleared");
    chk("irq_held", {31'b0, user_interrupt}, 32'h1);
    g_mode = 0;
    bus_wr(6'h0C, 32'h0);
    chk("irq_cleared", {31'b0, user_interrupt}, 32'h0);
    bus_wr(6'h00, 32'h1);
    repeat (1000) tick();
    bus_wr(6'h00, 32'h1);
    wait_irq(5000, "rearm_irq");
    rd(6'h0C, 32'h2, "rearm_status");
    bus_wr(6'h04, 32'd30);
    bus_wr(6'h00, 32'h1);
    repeat (6000) tick();
    rd(6'h0C, 32'h1, "line_oob_busy");
    chk("line_oob_irq", {31'b0, user_interrupt}, 32'h0);
    bus_wr(6'h00, 32'h0);
    rd(6'h0C, 32'h0, "abort_status");
    g_hhi = 1;
    repeat (500) tick();
    rd(6'h14, 32'd90, "hwidth_wrong_pol");
    bus_wr(6'h00, 32'h2);
    repeat (500) tick();
    rd(6'h14, 32'd10, "hwidth_hpol");
    rd(6'h10, 32'd100, "hperiod_hpol");
    for (int r = 0; r < 6; r++) begin
      g_p = $urandom_range(60, 120); g_w = $urandom_range(4, 20);
      g_l = $urandom_range(8, 16); g_vs = $urandom_range(1, 3);
      g_hhi = 1'($urandom); g_vhi = 1'($urandom);
      ls = r == 0 ? 0 : r == 1 ? g_l - 2 : $urandom_range(0, g_l - 2);
      xs = r == 0 ? 0 : r == 1 ? g_p : $urandom_range(0, g_p);
      bus_wr(6'h04, 32'(ls));
      bus_wr(6'h08, 32'(xs));
      bus_wr(6'h00, {28'b0, 1'($urandom), g_vhi, g_hhi, 1'b1});
      wait_irq(3 * g_l * g_p + 500, "rand_cap_irq");
      foreach (regs[i]) rd_any(regs[i]);
      bus_wr(6'h0C, 32'($urandom));
      bus_wr(6'h00, {29'b0, g_vhi, g_hhi, 1'b0});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule

// File: doc/tqvp_rejunity_vga_capture.md
Name: tqvp_rejunity_vga_capture

Overview:
TinyQV peripheral that receives a VGA-style 1-bpp signal (hsync, vsync, pixel) on the input PMOD. It is the receiving end of the 1-bpp VGA output peripheral.
- Measures line period, hsync width and lines per frame continuously.
- On request, captures CAP_BITS consecutive pixel samples from one selected line into CPU-readable registers.
- Raises user_interrupt when a capture completes.

Parameters:
CAP_BITS, 64, pixels captured per request; 32 or 64 only.
CNT_W, 16, width of horizontal counters (HPERIOD, HWIDTH, XSTART).

Ports:
clk  input  1  project clock (64 MHz nominal)
rst_n  input  1  reset
ui_in  input  8  [0]=hsync, [1]=vsync, [2]=pixel; already synchronized; other bits unused
uo_out  output  8  tied 0
address  input  6  register address
data_in  input  32  write data
data_write_n  input  2  11=no write, else write (8/16/32 all accepted; low bits used)
data_read_n  input  2  11=no read
data_out  output  32  read data
data_ready  output  1  constant 1
user_interrupt  output  1  equals done flag

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk. All registers, counters, flags and data_out are 0; FSM is in IDLE.
- Register map (word addresses):
  - 0x00 CTRL r/w: [0] ARM, [1] HPOL (1=active high), [2] VPOL, [3] CONT (optional feature).
  - 0x04 LINE r/w [9:0].
  - 0x08 XSTART r/w [CNT_W-1:0].
  - 0x0C STATUS: read [0] busy, [1] done; any write clears done.
  - 0x10 HPERIOD r. 0x14 HWIDTH r. 0x18 VLINES r [10:0].
  - 0x20 CAP0 r (pixel i at bit i). 0x24 CAP1 r (pixels 32..63; reads 0 when CAP_BITS=32).
  - Unmapped addresses read 0 and ignore writes.
- Reads: data_out is combinational from address when data_read_n!=11, else 0. 8- and 16-bit reads return the low bits.
- Sync decode:
  - hs_act = ui_in[0] XNOR HPOL; vs_act likewise with VPOL. Previous values are registered.
  - Leading edge = act & ~prev. Trailing edge = ~act & prev.
- Horizontal measurement:
  - h_cnt <= 1 on a leading-edge cycle; otherwise increments, saturating at all-ones.
  - At a leading edge, HPERIOD <= h_cnt. At a trailing edge, HWIDTH <= h_cnt.
  - Result: sync period P with width W reads HPERIOD=P, HWIDTH=W.
- Vertical measurement:
  - v_cnt counts hsync leading edges, saturating at 2047.
  - At a vsync leading edge, VLINES <= v_cnt and v_cnt <= 0. A coincident hsync edge counts into the new frame.
- Capture FSM (IDLE, ARM, LINES, CAPTURE):
  - CTRL write with [0]=1 from any state → ARM; done is cleared.
  - CTRL write with [0]=0 → IDLE; done is unchanged.
  - ARM: on a vsync leading edge → LINES, line_cnt=0.
  - LINES: on an hsync leading edge, if line_cnt==LINE → CAPTURE with x_cnt=0; else line_cnt++.
  - LINES: a vsync leading edge resets line_cnt to 0. A LINE value ≥ lines per frame therefore never completes.
  - CAPTURE: pixel i = ui_in[2] sampled exactly XSTART+i clocks after the cycle the hsync leading edge was detected, for i=0..CAP_BITS-1. XSTART=0 samples on the edge cycle itself.
  - CAPTURE: sync edges are ignored.
  - After the last sample → IDLE; CTRL[0] <= 0, done <= 1.
- Flags:
  - busy = state != IDLE.
  - user_interrupt = done. If done is set in the same cycle as a STATUS write, set wins.
- Capture registers hold their value until overwritten by the next capture. Partial captures aborted mid-way leave partially written bits.

Optional Feature:
VGA_CAP_CONT_EN:
- Defined: CTRL[3]=1 makes completion return to ARM instead of IDLE. CTRL[0] stays 1 and done is set every frame.
- Not defined: CTRL[3] reads 0 and is ignored.

Test Plan:
1. Reset, then read every register → all 0; user_interrupt=0; uo_out=0; data_ready=1.
2. Active-low sync, period 100 clk, width 10, 20 lines/frame, vsync 2 lines, run 2 frames → HPERIOD=100, HWIDTH=10, VLINES=20.
3. LINE=5, XSTART=20, arm; on line 5 drive pixel=1 at offsets 20, 21 and 83 only → CAP0=0x00000003, CAP1=0x80000000, STATUS=0x2, CTRL[0]=0, interrupt=1.
4. After test 3, write STATUS=0 → interrupt 0 on the next cycle. Re-arm while busy → no interrupt until a capture completes; the count restarts from the next vsync.
5. LINE=30 with 20 lines/frame, run 3 frames → busy=1, no interrupt. Then write CTRL=0 → STATUS=0.
6. Drive active-high hsync of width 10 with HPOL=0 → HWIDTH=90; set HPOL=1 → HWIDTH=10.
